// File: rtl/enc_pkg.sv
// Shared types and the fixed-priority encode helper for the 4-to-2 event encoder.
package enc_pkg;

  typedef logic [1:0] code_t;

  localparam int NLINES = 4;

  function automatic code_t pri_enc(input logic [3:0] v);
    code_t c;
    if (v[3]) begin
      c = 2'd3;
    end else if (v[2]) begin
      c = 2'd2;
    end else if (v[1]) begin
      c = 2'd1;
    end else begin
      c = 2'd0;
    end
    return c;
  endfunction

endpackage

// File: rtl/enc_4_2_evt_code_fifo.sv
// Code FIFO: register array with count-derived full/empty and wrapping pointers.
module code_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic [1:0],
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  T              din,
  output T              dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; full blocks push even alongside a pop.
  always_comb begin
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= T'(0);
      end
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/enc_4_2_evt.sv
// Event-driven 4-to-2 encoder: rising edges on d become queued 2-bit codes.
module enc_4_2_evt
  import enc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NLINES-1:0]        d,
  input  logic                     ovf_clr,
  input  logic                     ready,
  output logic [1:0]               y,
  output logic                     valid,
  output logic                     ovf,
  output logic [$clog2(DEPTH):0]   count
);

  logic [NLINES-1:0] d_q, d_d;
  logic [NLINES-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic [NLINES-1:0] rise_s, clr_s;
  code_t             sel_s;
  logic              push_s, pop_s, ovf_set_s;
  logic              full_s, empty_s;
  code_t             head_s;

  // Edge detect, selection, pending bookkeeping and overflow; a new rise beats the push-clear.
  always_comb begin
    d_d       = d;
    rise_s    = d & ~d_q;
    sel_s     = pri_enc(pend_q);
    push_s    = (pend_q != 4'b0000) && !full_s;
    pop_s     = !empty_s && ready;
    if (push_s) begin
      clr_s = 4'b0001 << sel_s;
    end else begin
      clr_s = 4'b0000;
    end
    pend_d    = (pend_q & ~clr_s) | rise_s;
    ovf_set_s = |(rise_s & pend_q & ~clr_s);
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Registers; d_q resets high so lines already asserted at release raise nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q    <= 4'b1111;
      pend_q <= 4'b0000;
      ovf_q  <= 1'b0;
    end else begin
      d_q    <= d_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  code_fifo #(
    .DEPTH (DEPTH),
    .T     (code_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (sel_s),
    .dout  (head_s),
    .count (count),
    .full  (full_s),
    .empty (empty_s)
  );

  assign y     = head_s;
  assign valid = !empty_s;
  assign ovf   = ovf_q;

endmodule
